// File: rtl/gru_ctrl_pkg.sv
// Shared control types and latency constants for the GRU cell sequencers.
// The index delay-line depth follows from the memory and gate-element latencies.
package gru_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int MEM_RD_LAT     = 1;
    localparam int ELEM_LAT       = 1;
    localparam int IDX_PIPE_DEPTH = MEM_RD_LAT + ELEM_LAT;

endpackage

// File: rtl/gru_idx_delay_line.sv
// Shift register of {valid, index} that tracks rows in flight through
// the weight memory and the gate element; clear drops every entry.
module gru_idx_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         head_valid_o,
    output logic         tail_valid_o,
    output logic [W-1:0] tail_data_o
);

    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0][W-1:0] dat_q;

    // Advance every entry one stage per clock; clear empties the line.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign head_valid_o = vld_q[0];
    assign tail_valid_o = vld_q[DEPTH-1];
    assign tail_data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/gru_gate_row_scheduler.sv
// Walks rows 0..H-1 through one shared GRU gate element, issuing weight
// reads and writing each returned gate value to the result buffer.
module gru_gate_row_scheduler
    import gru_ctrl_pkg::*;
#(
    parameter int H          = 256,
    parameter int INT_BITS   = 16,
    parameter int FRAC_BITS  = 8,
    parameter int DATA_WIDTH = INT_BITS + FRAC_BITS,
    parameter int IDX_W      = $clog2(H)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_req,
    input  logic                         mem_grant,
    output logic [IDX_W-1:0]             mem_addr,
    output logic                         elem_valid_in,
    input  logic                         elem_valid_out,
    input  logic signed [DATA_WIDTH-1:0] elem_z,
    output logic                         res_we,
    output logic [IDX_W-1:0]             res_addr,
    output logic signed [DATA_WIDTH-1:0] res_data
);

    localparam int            CW   = IDX_W + 1;
    localparam logic [CW-1:0] LAST = CW'(H - 1);

    sched_state_t state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] w_q, w_d;

    logic issue;
    logic last_wr;
    logic wr_fire;
    logic tail_vld;
    logic [IDX_W-1:0] tail_idx;

    logic                         res_we_q;
    logic [IDX_W-1:0]             res_addr_q;
    logic signed [DATA_WIDTH-1:0] res_data_q;

    assign issue   = (state_q == ISSUE) && mem_grant;
    assign last_wr = res_we_q && (w_q == LAST);
    assign wr_fire = elem_valid_out && tail_vld;

    assign mem_addr = n_q[IDX_W-1:0];
    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;

    // Next state, counters and control outputs; abort overrides all of it.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        w_d     = w_q;
        mem_req = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        if (res_we_q) begin
            w_d = w_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    n_d     = '0;
                    w_d     = '0;
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (issue) begin
                    n_d = n_q + 1'b1;
                    if (n_q == LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            n_d     = '0;
            w_d     = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            w_q     <= w_d;
        end
    end

    // Register a result when the element answers for a tracked row.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            res_we_q <= wr_fire && !abort;
            if (wr_fire && !abort) begin
                res_addr_q <= tail_idx;
                res_data_q <= elem_z;
            end
        end
    end

    gru_idx_delay_line #(
        .DEPTH (IDX_PIPE_DEPTH),
        .W     (IDX_W)
    ) u_idx_dl (
        .clk          (clk),
        .clear_i      (reset || abort),
        .valid_i      (issue),
        .data_i       (mem_addr),
        .head_valid_o (elem_valid_in),
        .tail_valid_o (tail_vld),
        .tail_data_o  (tail_idx)
    );

endmodule

// File: tb/tb_gru_gate_row_scheduler.sv
// Directed bench for gru_gate_row_scheduler: an H=4 instance for timing
// scenarios and an H=256 instance for randomly granted passes.
module tb_gru_gate_row_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tick = 0;
    int   t0 = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    // H=4 instance
    logic        start = 1'b0, abort = 1'b0, grant = 1'b1, spur = 1'b0;
    logic        busy, done, mreq, evi, evo, we;
    logic [1:0]  maddr, raddr;
    logic signed [23:0] ez, rdata;
    logic [1:0]  row_q;
    logic        evo_q = 1'b0;

    gru_gate_row_scheduler #(.H(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .mem_req(mreq), .mem_grant(grant),
        .mem_addr(maddr), .elem_valid_in(evi), .elem_valid_out(evo),
        .elem_z(ez), .res_we(we), .res_addr(raddr), .res_data(rdata)
    );

    // Memory (1 cycle) plus gate element (1 cycle) returning z = row + 1.
    always @(posedge clk) begin
        if (mreq && grant) row_q <= maddr;
        evo_q <= evi;
        ez    <= 24'(row_q) + 24'sd1;
    end
    assign evo = evo_q | spur;

    // H=256 instance
    logic        start2 = 1'b0, abort2 = 1'b0, grant2 = 1'b0;
    logic        busy2, done2, mreq2, evi2, evo2, we2;
    logic [7:0]  maddr2, raddr2, row2_q;
    logic signed [23:0] ez2, rdata2;

    gru_gate_row_scheduler #(.H(256)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .mem_req(mreq2), .mem_grant(grant2),
        .mem_addr(maddr2), .elem_valid_in(evi2), .elem_valid_out(evo2),
        .elem_z(ez2), .res_we(we2), .res_addr(raddr2), .res_data(rdata2)
    );

    always @(posedge clk) begin
        if (mreq2 && grant2) row2_q <= maddr2;
        evo2 <= evi2;
        ez2  <= 24'(row2_q) + 24'sd1;
    end

    // Per-cycle log of the H=4 outputs, sampled mid-cycle.
    logic        lg_we[1024], lg_busy[1024], lg_done[1024];
    logic        lg_evi[1024], lg_mreq[1024];
    logic [1:0]  lg_addr[1024], lg_maddr[1024];
    logic [23:0] lg_data[1024];

    always @(negedge clk) begin
        lg_we[tick & 1023]    = we;
        lg_busy[tick & 1023]  = busy;
        lg_done[tick & 1023]  = done;
        lg_evi[tick & 1023]   = evi;
        lg_mreq[tick & 1023]  = mreq;
        lg_addr[tick & 1023]  = raddr;
        lg_maddr[tick & 1023] = maddr;
        lg_data[tick & 1023]  = rdata;
    end

    function automatic logic [4:0] obs(input int c);
        int a;
        a = (t0 + c) & 1023;
        return {lg_we[a], lg_busy[a], lg_done[a], lg_evi[a], lg_mreq[a]};
    endfunction

    function automatic int li(input int c);
        return (t0 + c) & 1023;
    endfunction

    // Drive the H=4 instance cycle by cycle; cycle 0 is the first one driven.
    task automatic run_pass(input int n, input int s0, input int s1,
                            input int g0, input int g1, input int ab,
                            input int rs, input int sp0, input int sp1);
        @(posedge clk); #1;
        t0 = tick;
        for (int c = 0; c < n; c++) begin
            start = (c >= s0) && (c <= s1);
            grant = !((c >= g0) && (c <= g1));
            abort = (c == ab);
            reset = (c == rs);
            spur  = (c >= sp0) && (c <= sp1);
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0; spur = 1'b0; grant = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, done, mreq, evi, we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 00000", {busy, done, mreq, evi, we});
        end
        n_tests++;
        if ({maddr, raddr, rdata} !== 28'b0) begin
            n_fail++;
            $display("FAIL reset_bus got %h want 0", {maddr, raddr, rdata});
        end
        n_tests++;
        if ({busy2, done2, mreq2, evi2, we2, maddr2, raddr2, rdata2} !== 45'b0) begin
            n_fail++;
            $display("FAIL reset_h256 got %h want 0",
                     {busy2, done2, mreq2, evi2, we2, maddr2, raddr2, rdata2});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic(input string tag);
        logic [31:0] m_we, m_bs, m_dn, m_ev, m_rq;
        logic [4:0]  e;
        int wk;
        m_we = 32'hF0; m_bs = 32'hFE; m_dn = 32'h100;
        m_ev = 32'h3C; m_rq = 32'h1E;
        run_pass(12, 0, 0, -1, -2, -1, -1, -1, -2);
        wk = 0;
        for (int c = 0; c < 12; c++) begin
            e = {m_we[c], m_bs[c], m_dn[c], m_ev[c], m_rq[c]};
            n_tests++;
            if (obs(c) !== e) begin
                n_fail++;
                $display("FAIL %s c=%0d got %b want %b (we,busy,done,evi,req)",
                         tag, c, obs(c), e);
            end
            if (lg_we[li(c)] === 1'b1) begin
                n_tests++;
                if (lg_addr[li(c)] !== 2'(wk) || lg_data[li(c)] !== 24'(wk + 1)) begin
                    n_fail++;
                    $display("FAIL %s_wr c=%0d got %0d/%0d want %0d/%0d", tag, c,
                             lg_addr[li(c)], lg_data[li(c)], wk, wk + 1);
                end
                wk++;
            end
        end
        n_tests++;
        if (wk !== 4) begin
            n_fail++;
            $display("FAIL %s_count got %0d want 4", tag, wk);
        end
    endtask

    task automatic test_grant_gap();
        logic [31:0] m_we, m_bs, m_dn, m_ev, m_rq;
        logic [4:0]  e;
        int wk;
        m_we = 32'h390; m_bs = 32'h3FE; m_dn = 32'h400;
        m_ev = 32'hE4;  m_rq = 32'h7E;
        run_pass(14, 0, 0, 2, 3, -1, -1, -1, -2);
        wk = 0;
        for (int c = 0; c < 14; c++) begin
            e = {m_we[c], m_bs[c], m_dn[c], m_ev[c], m_rq[c]};
            n_tests++;
            if (obs(c) !== e) begin
                n_fail++;
                $display("FAIL gap c=%0d got %b want %b (we,busy,done,evi,req)",
                         c, obs(c), e);
            end
            if (lg_we[li(c)] === 1'b1) begin
                n_tests++;
                if (lg_addr[li(c)] !== 2'(wk) || lg_data[li(c)] !== 24'(wk + 1)) begin
                    n_fail++;
                    $display("FAIL gap_wr c=%0d got %0d/%0d want %0d/%0d", c,
                             lg_addr[li(c)], lg_data[li(c)], wk, wk + 1);
                end
                wk++;
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] m_bs, m_ev, m_rq;
        logic [4:0]  e;
        m_bs = 32'hE; m_ev = 32'hC; m_rq = 32'hE;
        run_pass(12, 0, 0, -1, -2, 3, -1, -1, -2);
        for (int c = 0; c < 12; c++) begin
            e = {1'b0, m_bs[c], 1'b0, m_ev[c], m_rq[c]};
            n_tests++;
            if (obs(c) !== e) begin
                n_fail++;
                $display("FAIL abort c=%0d got %b want %b (we,busy,done,evi,req)",
                         c, obs(c), e);
            end
        end
    endtask

    task automatic test_start_behaviour();
        logic [31:0] m_we, m_bs, m_dn, m_ev, m_rq;
        logic [4:0]  e;
        int wk;
        m_we = 32'hF0; m_bs = 32'hFE; m_dn = 32'h100;
        m_ev = 32'h3C; m_rq = 32'h1E;
        run_pass(12, 0, 5, -1, -2, -1, -1, -1, -2);
        for (int c = 0; c < 12; c++) begin
            e = {m_we[c], m_bs[c], m_dn[c], m_ev[c], m_rq[c]};
            n_tests++;
            if (obs(c) !== e) begin
                n_fail++;
                $display("FAIL start_busy c=%0d got %b want %b (we,busy,done,evi,req)",
                         c, obs(c), e);
            end
        end
        m_we = 32'h1E0F0; m_bs = 32'h1FCFE; m_dn = 32'h20100;
        m_ev = 32'h783C;  m_rq = 32'h3C1E;
        run_pass(22, 0, 9, -1, -2, -1, -1, -1, -2);
        wk = 0;
        for (int c = 0; c < 22; c++) begin
            e = {m_we[c], m_bs[c], m_dn[c], m_ev[c], m_rq[c]};
            n_tests++;
            if (obs(c) !== e) begin
                n_fail++;
                $display("FAIL start_held c=%0d got %b want %b (we,busy,done,evi,req)",
                         c, obs(c), e);
            end
            if (lg_we[li(c)] === 1'b1) begin
                n_tests++;
                if (lg_addr[li(c)] !== 2'(wk % 4) || lg_data[li(c)] !== 24'(wk % 4 + 1)) begin
                    n_fail++;
                    $display("FAIL start_held_wr c=%0d got %0d/%0d want %0d/%0d", c,
                             lg_addr[li(c)], lg_data[li(c)], wk % 4, wk % 4 + 1);
                end
                wk++;
            end
        end
    endtask

    task automatic test_reset_drain();
        logic [31:0] m_we, m_bs, m_ev, m_rq;
        logic [4:0]  e;
        m_we = 32'h70; m_bs = 32'h7E; m_ev = 32'h3C; m_rq = 32'h1E;
        run_pass(14, 0, 0, -1, -2, -1, 6, 9, 10);
        for (int c = 0; c < 14; c++) begin
            e = {m_we[c], m_bs[c], 1'b0, m_ev[c], m_rq[c]};
            n_tests++;
            if (obs(c) !== e) begin
                n_fail++;
                $display("FAIL rst_drain c=%0d got %b want %b (we,busy,done,evi,req)",
                         c, obs(c), e);
            end
            if (c >= 7) begin
                n_tests++;
                if ({lg_maddr[li(c)], lg_addr[li(c)], lg_data[li(c)]} !== 28'b0) begin
                    n_fail++;
                    $display("FAIL rst_drain_bus c=%0d got %h want 0", c,
                             {lg_maddr[li(c)], lg_addr[li(c)], lg_data[li(c)]});
                end
            end
        end
    endtask

    task automatic test_random_h256();
        int exp_idx, ndone, cyc;
        bit seen;
        ndone = 0;
        for (int p = 0; p < 20; p++) begin
            exp_idx = 0;
            seen = 1'b0;
            @(posedge clk); #1;
            start2 = 1'b1;
            grant2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc = 0;
            while (!seen && cyc < 3000) begin
                @(posedge clk); #1;
                start2 = 1'b0;
                grant2 = 1'($urandom_range(0, 1));
                @(negedge clk);
                cyc++;
                if (we2) begin
                    n_tests++;
                    if (raddr2 !== 8'(exp_idx) || rdata2 !== 24'(exp_idx + 1)) begin
                        n_fail++;
                        $display("FAIL rand p=%0d wr got %0d/%0d want %0d/%0d", p,
                                 raddr2, rdata2, exp_idx, exp_idx + 1);
                    end
                    exp_idx++;
                end
                if (done2) begin
                    seen = 1'b1;
                    ndone++;
                end
            end
            n_tests++;
            if (!seen || exp_idx != 256) begin
                n_fail++;
                $display("FAIL rand_pass p=%0d done=%0d writes=%0d want 1/256",
                         p, seen, exp_idx);
            end
            grant2 = 1'b0;
        end
        n_tests++;
        if (ndone != 20) begin
            n_fail++;
            $display("FAIL rand_done_count got %0d want 20", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_grant_gap();
        test_abort();
        test_basic("restart");
        test_start_behaviour();
        test_reset_drain();
        test_random_h256();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gru_gate_row_scheduler.md
# gru_gate_row_scheduler

Sequencer for one shared GRU gate-row datapath, such as the update-gate element that computes one z_t[n] per valid_in. On `start` it walks row index n = 0..H-1 and requests each weight row and its bias pair from the arbitrated weight memory. It then pulses the gate element's valid_in when the row data arrives and writes each returned gate value into the per-step result buffer at address n. It signals `done` after all H results are written, so the cell-level FSM can advance to the next gate or timestep.

## Interface
- `H`, 256: rows per pass (hidden size); H ≥ 2.
- `INT_BITS`, 16: integer bits of gate value.
- `FRAC_BITS`, 8: fractional bits of gate value.
- `DATA_WIDTH`, INT_BITS+FRAC_BITS: gate value width.
- `IDX_W`, $clog2(H): row index width.
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of the current pass.
- `busy`  out  1  high from first ISSUE cycle through last result write.
- `done`  out  1  one-cycle pulse after the last write.
- `mem_req`  out  1  request a weight-row read.
- `mem_grant`  in  1  arbiter grant; a read is issued in any cycle with mem_req & mem_grant.
- `mem_addr`  out  IDX_W  row index of the issued read.
- `elem_valid_in`  out  1  to gate element; row data is on the memory bus this cycle.
- `elem_valid_out`  in  1  from gate element (registered, 1-cycle latency).
- `elem_z`  in  DATA_WIDTH signed  gate element result.
- `res_we`  out  1  result buffer write strobe.
- `res_addr`  out  IDX_W  result buffer address.
- `res_data`  out  DATA_WIDTH signed  result value.

## Operation
- FSM states:
  - IDLE: `start` → ISSUE.
  - ISSUE: the issue of row H-1 → DRAIN.
  - DRAIN: the write of row H-1 → DONE.
  - DONE: unconditional → IDLE.
- `start` is ignored outside IDLE.
- `mem_req` is high only in ISSUE. `mem_addr` = issue counter `n`. `n` increments only on `mem_req & mem_grant`. `mem_grant` without `mem_req` is ignored.
- Memory read latency is fixed at 1 cycle. `elem_valid_in` = issue strobe delayed 1 cycle; the row index travels in a matching delay line.
- Index delay line depth is 2 (memory + element). On `elem_valid_out` the aligned index and `elem_z` are registered into `res_*`.
- A write counter counts `res_we`; DRAIN exits when the write for index H-1 is made.
- `elem_valid_out` with no in-flight entry is dropped (no write).
- Counters are IDX_W+1 bits wide; no wrap within a pass. `n` resets to 0 on each `start`.
- `abort` in any state:
  - next cycle is IDLE;
  - in-flight valids cleared;
  - no further `elem_valid_in` or `res_we`;
  - `done` is not pulsed.
- `abort` has priority over `start` and over all state transitions.
- Grant gaps: issue stalls, in-flight rows still drain normally. Results are written in ascending index order.
- Reset values: `busy`, `done`, `mem_req`, `elem_valid_in`, `res_we` = 0; `mem_addr`, `res_addr`, `res_data` = 0; state IDLE; counters 0.

## Timing
- Cycle 0: `start` high in IDLE. Cycle 1: ISSUE, `mem_req`=1, `busy`=1.
- Read granted in cycle k, row n:
  - `elem_valid_in` in cycle k+1;
  - `elem_valid_out` in cycle k+2;
  - `res_we`/`res_addr`=n/`res_data` in cycle k+3.
- With continuous grant: last issue in cycle H, last write in cycle H+3, `done` in cycle H+4 (`busy`=0 that cycle), IDLE in cycle H+5.
- Maximum throughput is one row per cycle. The pipeline holds at most 2 in-flight rows.
- Reset asserted mid-pass: all outputs take reset values the next cycle; no write or `done` follows.

## Structure
- Shared package `gru_ctrl_pkg`:
  - `sched_state_t` enum (IDLE, ISSUE, DRAIN, DONE);
  - `MEM_RD_LAT` = 1;
  - `ELEM_LAT` = 1.
  - The delay-line depth is derived from these two constants.
- Sub-module `gru_idx_delay_line`: parameterized depth and width shift register of {valid, index}, clearable by `abort`/`reset`.
- The gate element and weight memory are instantiated outside this block.

## Test plan
- H=4, `mem_grant` tied 1, `start` at cycle 0, element model returns z=n+1 → writes (0,1),(1,2),(2,3),(3,4) in cycles 4..7; `done` in cycle 8 only; `busy` high cycles 1..7.
- H=4, `mem_grant` low in cycles 2–3 → row 1 issues in cycle 4; writes stay in index order; `done` in cycle 10.
- `abort` in cycle 3 of an H=4 pass → IDLE in cycle 4; no `res_we` or `elem_valid_in` from cycle 4; no `done`; a new `start` then completes normally.
- `start` re-asserted while busy → ignored: exactly 4 writes and one `done`. `start` held high through DONE → a second pass begins from IDLE.
- `reset` asserted in DRAIN → next cycle all outputs 0, state IDLE, no `done`. Spurious `elem_valid_out` in IDLE → no write.
- H=256, random 50% grant over 20 passes → every index written exactly once per pass, ascending; `done` count = 20.
